// File: rtl/gpu_pkg.sv
// gpu_pkg: shared definitions for the instruction sequencer.
//   - opcode encodings (controller-class and memory-class)
//   - instruction field bit positions (op, rd, imm; low byte is opaque payload)
//   - controller FSM state type
//   - is_mem_op(): true for opcodes forwarded verbatim to the memory module
package gpu_pkg;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_SETR   = 4'h1;
   localparam logic [3:0] OP_ADDR   = 4'h2;
   localparam logic [3:0] OP_BNZ    = 4'h3;
   localparam logic [3:0] OP_SMA    = 4'h6;
   localparam logic [3:0] OP_LOADI  = 4'h7;
   localparam logic [3:0] OP_SENDL  = 4'h8;
   localparam logic [3:0] OP_LOADB  = 4'h9;
   localparam logic [3:0] OP_WRITEB = 4'hA;
   localparam logic [3:0] OP_HALT   = 4'hF;

   localparam int unsigned OP_MSB  = 31;
   localparam int unsigned OP_LSB  = 28;
   localparam int unsigned RD_MSB  = 27;
   localparam int unsigned RD_LSB  = 24;
   localparam int unsigned IMM_MSB = 23;
   localparam int unsigned IMM_LSB = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      ISSUE,
      HALT
   } ctrl_state_t;

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_SMA) || (op == OP_LOADI) || (op == OP_SENDL) ||
             (op == OP_LOADB) || (op == OP_WRITEB);
   endfunction

endpackage

// File: rtl/private_reg_file.sv
// private_reg_file: Count x Width register file private to the sequencer.
//   clk_i    : clock
//   rst_ni   : synchronous active-low clear of every register
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : write data
//   raddr_i  : read index
//   rdata_o  : combinational read data
module private_reg_file #(
   parameter int unsigned Width = 16,
   parameter int unsigned Count = 16,
   localparam int unsigned IdxW = (Count > 1) ? $clog2(Count) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            we_i,
   input  logic [IdxW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [IdxW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] regs_q [Count];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < Count; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/gpu_controller.sv
// gpu_controller: instruction sequencer feeding the memory module.
//   clk_in                 : system clock
//   rst_in                 : synchronous active-low reset
//   start_in               : pulse, begin execution at PC 0 (ignored while running)
//   instr_addr_out         : instruction BRAM read address
//   instr_data_in          : BRAM data, sampled on the ROM_LATENCY-th edge after the address
//   memory_idle_in         : memory module idle flag
//   memory_instr_out       : last issued instruction (qualify with valid)
//   memory_instr_valid_out : one-cycle issue strobe
//   busy_out               : high from start until halt
//   done_out               : one-cycle pulse on halt
// Memory-class opcodes are forwarded one at a time; controller-class opcodes
// (SETR, ADDR, BNZ, HALT) execute locally against a private register file.
module gpu_controller
   import gpu_pkg::*;
#(
   parameter int unsigned INSTRUCTION_WIDTH = 32,
   parameter int unsigned INSTRUCTION_COUNT = 8,
   parameter int unsigned PRIVATE_REG_WIDTH = 16,
   parameter int unsigned PRIVATE_REG_COUNT = 16,
   parameter int unsigned ROM_LATENCY       = 2,
   localparam int unsigned AW   = (INSTRUCTION_COUNT > 1) ? $clog2(INSTRUCTION_COUNT) : 1,
   localparam int unsigned RIW  = (PRIVATE_REG_COUNT > 1) ? $clog2(PRIVATE_REG_COUNT) : 1
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start_in,
   output logic [AW-1:0]                instr_addr_out,
   input  logic [INSTRUCTION_WIDTH-1:0] instr_data_in,
   input  logic                         memory_idle_in,
   output logic [INSTRUCTION_WIDTH-1:0] memory_instr_out,
   output logic                         memory_instr_valid_out,
   output logic                         busy_out,
   output logic                         done_out
);

   localparam int unsigned CW = $clog2(ROM_LATENCY + 1);
   localparam logic [CW-1:0] CntLast = CW'(ROM_LATENCY - 1);
   localparam logic [AW-1:0] PcLast  = AW'(INSTRUCTION_COUNT - 1);

   ctrl_state_t                  state_q;
   logic [AW-1:0]                pc_q;
   logic [AW-1:0]                addr_q;
   logic [CW-1:0]                cnt_q;
   logic [INSTRUCTION_WIDTH-1:0] instr_q;
   logic [INSTRUCTION_WIDTH-1:0] last_q;
   logic                         busy_q;
   logic                         done_q;

   // Field decode of the latched instruction
   logic [3:0]                   op;
   logic [3:0]                   rd;
   logic [15:0]                  imm;
   assign op  = instr_q[OP_MSB:OP_LSB];
   assign rd  = instr_q[RD_MSB:RD_LSB];
   assign imm = instr_q[IMM_MSB:IMM_LSB];

   logic                         reg_we;
   logic [PRIVATE_REG_WIDTH-1:0] reg_wdata;
   logic [PRIVATE_REG_WIDTH-1:0] reg_rdata;

   assign reg_we    = (state_q == EXEC) && ((op == OP_SETR) || (op == OP_ADDR));
   assign reg_wdata = (op == OP_SETR) ? PRIVATE_REG_WIDTH'(imm)
                                      : reg_rdata + PRIVATE_REG_WIDTH'(imm);

   private_reg_file #(
      .Width (PRIVATE_REG_WIDTH),
      .Count (PRIVATE_REG_COUNT)
   ) u_reg_file (
      .clk_i   (clk_in),
      .rst_ni  (rst_in),
      .we_i    (reg_we),
      .waddr_i (rd[RIW-1:0]),
      .wdata_i (reg_wdata),
      .raddr_i (rd[RIW-1:0]),
      .rdata_o (reg_rdata)
   );

   // Next-PC resolution for controller-class instructions in EXEC.
   // Stepping past the last slot, or branching outside the program, halts.
   logic                         pc_last;
   logic [AW-1:0]                pc_inc;
   logic [AW-1:0]                target;
   logic                         exec_halt;
   logic [AW-1:0]                exec_pc;

   assign pc_last = (pc_q == PcLast);
   assign pc_inc  = pc_q + AW'(1);
   assign target  = imm[AW-1:0];

   always_comb begin
      exec_halt = 1'b0;
      exec_pc   = pc_inc;
      if (op == OP_HALT) begin
         exec_halt = 1'b1;
      end else if ((op == OP_BNZ) && (reg_rdata != '0)) begin
         exec_pc   = target;
         exec_halt = !(32'(target) < INSTRUCTION_COUNT);
      end else begin
         exec_halt = pc_last;
      end
   end

   // The strobe fires in the very cycle idle is seen high; rst_in gates it so
   // an abort can never leak a final issue.
   logic issue_fire;
   assign issue_fire = (state_q == ISSUE) && memory_idle_in && rst_in;

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
         pc_q    <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         instr_q <= '0;
         last_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_in) begin
                  pc_q    <= '0;
                  addr_q  <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               if (cnt_q == CntLast) begin
                  instr_q <= instr_data_in;
                  state_q <= EXEC;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            EXEC: begin
               if (is_mem_op(op)) begin
                  state_q <= ISSUE;
               end else if (exec_halt) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= HALT;
               end else begin
                  pc_q    <= exec_pc;
                  addr_q  <= exec_pc;
                  cnt_q   <= '0;
                  state_q <= FETCH;
               end
            end
            ISSUE: begin
               if (memory_idle_in) begin
                  last_q <= instr_q;
                  if (pc_last) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= HALT;
                  end else begin
                     pc_q    <= pc_inc;
                     addr_q  <= pc_inc;
                     cnt_q   <= '0;
                     state_q <= FETCH;
                  end
               end
            end
            HALT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign instr_addr_out         = addr_q;
   assign memory_instr_out       = issue_fire ? instr_q : last_q;
   assign memory_instr_valid_out = issue_fire;
   assign busy_out               = busy_q;
   assign done_out               = done_q;

endmodule

// File: tb/tb_gpu_controller.sv
// tb_gpu_controller: directed table, hand sequences and random programs for
// gpu_controller. A program-level reference model predicts the cycle of every
// issue strobe and of done, relative to the first cycle after the start edge.
module tb_gpu_controller;

   localparam int IC = 8;
   localparam int RL = 2;
   localparam int IDLE_LEN = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  addr;
   logic [31:0] rom_data;
   logic        mem_idle;
   logic [31:0] mem_instr;
   logic        valid;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   gpu_controller #(
      .INSTRUCTION_WIDTH (32),
      .INSTRUCTION_COUNT (IC),
      .PRIVATE_REG_WIDTH (16),
      .PRIVATE_REG_COUNT (16),
      .ROM_LATENCY       (RL)
   ) dut (
      .clk_in                 (clk),
      .rst_in                 (rst_n),
      .start_in               (start),
      .instr_addr_out         (addr),
      .instr_data_in          (rom_data),
      .memory_idle_in         (mem_idle),
      .memory_instr_out       (mem_instr),
      .memory_instr_valid_out (valid),
      .busy_out               (busy),
      .done_out               (done)
   );

   // Instruction BRAM: address driven after one edge, data ready before the
   // ROM_LATENCY-th edge after it (one registered read stage for latency 2).
   logic [31:0] prog [IC];
   always_ff @(posedge clk) rom_data <= prog[addr];

   typedef struct packed {
      int          cyc;
      logic [31:0] instr;
   } strobe_t;

   typedef struct packed {
      logic [7:0][31:0] prog;
      int               exp_strobes;
      int               exp_done;
      int               exp_first;
      logic [2:0]       exp_addr;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   bit          idle_pat [IDLE_LEN];
   logic [15:0] m_regs [16];
   strobe_t     exp_q[$];
   strobe_t     act_q[$];
   int          exp_done;
   int          act_done;
   logic [2:0]  act_addr_done;
   logic [31:0] act_mi_done;
   bit          wrapped;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic bit idle_at(input int c);
      return (c >= 0 && c < IDLE_LEN) ? idle_pat[c] : 1'b1;
   endfunction

   task automatic clear_model_regs();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
   endtask

   // Interprets the program: memory ops cost RL+1 cycles to the earliest strobe
   // plus any idle wait, controller ops cost RL+1 cycles; halting lands done
   // where the next fetch would have started.
   task automatic model_run();
      int pc = 0;
      int t = 0;
      int npc;
      int nxt;
      bit halt;
      logic [31:0] ins;
      logic [3:0] op;
      logic [3:0] rd;
      logic [15:0] imm;
      exp_q.delete();
      exp_done = -1;
      for (int steps = 0; steps < 256; steps++) begin
         ins = prog[pc];
         op  = ins[31:28];
         rd  = ins[27:24];
         imm = ins[23:8];
         npc = pc + 1;
         nxt = t + RL + 1;
         halt = 1'b0;
         if (op inside {4'h6, 4'h7, 4'h8, 4'h9, 4'hA}) begin
            while (!idle_at(nxt)) nxt++;
            exp_q.push_back('{cyc: nxt, instr: ins});
            nxt++;
         end else begin
            case (op)
               4'h1: m_regs[rd] = imm;
               4'h2: m_regs[rd] = m_regs[rd] + imm;
               4'h3: if (m_regs[rd] != 0) npc = int'(imm) % IC;
               4'hF: halt = 1'b1;
               default: ;
            endcase
         end
         if (npc >= IC) halt = 1'b1;
         if (halt) begin
            exp_done = nxt;
            return;
         end
         pc = npc;
         t  = nxt;
      end
   endtask

   // Starts the DUT and records strobes until three cycles past done.
   // sa: cycle at which a second start pulse is driven (-1 for none).
   task automatic run_dut(input int sa, input int limit);
      bit seen_nz = 1'b0;
      act_q.delete();
      act_done = -1;
      wrapped = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 0; c < limit; c++) begin
         mem_idle = idle_at(c);
         start = (c == sa);
         @(negedge clk);
         if (valid) act_q.push_back('{cyc: c, instr: mem_instr});
         if (addr != 3'd0) seen_nz = 1'b1;
         else if (seen_nz) wrapped = 1'b1;
         if (done && act_done < 0) begin
            act_done = c;
            act_addr_done = addr;
            act_mi_done = mem_instr;
         end
         if (exp_done >= 0) chk($sformatf("busy@%0d", c), busy, (c < exp_done));
         if (act_done >= 0 && c >= act_done + 3) break;
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      chk("done_seen", (act_done >= 0), 1);
   endtask

   task automatic compare_run(input string name);
      int n;
      chk({name, "_nstrobes"}, act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_cyc%0d", name, i), act_q[i].cyc, exp_q[i].cyc);
         chk($sformatf("%s_ins%0d", name, i), act_q[i].instr, exp_q[i].instr);
      end
      chk({name, "_done_cyc"}, act_done, exp_done);
      chk({name, "_no_wrap"}, wrapped, 0);
      if (exp_q.size() > 0) chk({name, "_hold"}, act_mi_done, exp_q[exp_q.size()-1].instr);
   endtask

   task automatic load_prog(input logic [7:0][31:0] p);
      for (int i = 0; i < IC; i++) prog[i] = p[i];
   endtask

   task automatic idle_all_high();
      for (int i = 0; i < IDLE_LEN; i++) idle_pat[i] = 1'b1;
   endtask

   initial begin
      vec_t             vecs [4];
      logic [7:0][31:0] p;
      int               stray;
      int               first;
      int               sa;
      logic [31:0]      w;

      // Directed table with hand-derived strobe counts and done cycles
      for (int j = 0; j < 4; j++) vecs[j] = '0;
      vecs[0].prog[0] = 32'h6000_0100;
      for (int j = 1; j < 7; j++) vecs[0].prog[j] = 32'h7100_0000 + 32'(j * 257);
      vecs[0].prog[7] = 32'h8000_0000;
      vecs[0].exp_strobes = 8; vecs[0].exp_done = 32; vecs[0].exp_first = 3;
      vecs[0].exp_addr = 3'd7;
      vecs[1].prog[0] = 32'h1100_0300;
      vecs[1].prog[1] = 32'hA000_0042;
      vecs[1].prog[2] = 32'h21FF_FF00;
      vecs[1].prog[3] = 32'h3100_0100;
      vecs[1].prog[4] = 32'hF000_0000;
      vecs[1].exp_strobes = 3; vecs[1].exp_done = 36; vecs[1].exp_first = 6;
      vecs[1].exp_addr = 3'd4;
      vecs[2].exp_strobes = 0; vecs[2].exp_done = 24; vecs[2].exp_first = -1;
      vecs[2].exp_addr = 3'd7;
      vecs[3].prog[0] = 32'h4000_0000;
      vecs[3].prog[1] = 32'h6000_0100;
      vecs[3].prog[2] = 32'h5A00_0000;
      vecs[3].prog[3] = 32'hF000_0000;
      vecs[3].exp_strobes = 1; vecs[3].exp_done = 13; vecs[3].exp_first = 6;
      vecs[3].exp_addr = 3'd3;

      rst_n = 1'b0; start = 1'b0; mem_idle = 1'b1;
      for (int i = 0; i < IC; i++) prog[i] = '0;
      idle_all_high();
      clear_model_regs();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_addr", addr, 0);
      chk("rst_valid", valid, 0);
      chk("rst_instr", mem_instr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         load_prog(vecs[v].prog);
         idle_all_high();
         model_run();
         run_dut(-1, 600);
         compare_run($sformatf("vec%0d", v));
         first = (act_q.size() > 0) ? act_q[0].cyc : -1;
         chk($sformatf("vec%0d_nstrobes_tab", v), act_q.size(), vecs[v].exp_strobes);
         chk($sformatf("vec%0d_done_tab", v), act_done, vecs[v].exp_done);
         chk($sformatf("vec%0d_first_tab", v), first, vecs[v].exp_first);
         chk($sformatf("vec%0d_addr_done", v), act_addr_done, vecs[v].exp_addr);
         if (v == 1) chk("loop_r1_zero", dut.u_reg_file.regs_q[1], 0);
      end

      // Stall: idle low for 5 cycles once WRITEB is fetched
      p = '0;
      p[0] = 32'hA000_0055;
      p[1] = 32'hF000_0000;
      load_prog(p);
      idle_all_high();
      for (int i = 2; i <= 6; i++) idle_pat[i] = 1'b0;
      model_run();
      run_dut(-1, 200);
      compare_run("stall");
      chk("stall_count", act_q.size(), 1);
      if (act_q.size() > 0) chk("stall_cyc", act_q[0].cyc, 7);
      chk("stall_done", act_done, 11);

      // Start while busy plus unknown opcode 0100
      p = '0;
      p[0] = 32'h4300_00AA;
      p[1] = 32'h6000_0100;
      p[2] = 32'h7200_0300;
      p[4] = 32'h8000_0000;
      p[5] = 32'hF000_0000;
      load_prog(p);
      idle_all_high();
      model_run();
      run_dut(5, 200);
      compare_run("restart_ign");
      chk("restart_ign_count", act_q.size(), 3);
      chk("restart_ign_done", act_done, 21);

      // Reset in the middle of a stalled ISSUE
      p = '0;
      p[0] = 32'h1200_0500;
      p[1] = 32'hA000_0077;
      p[2] = 32'hF000_0000;
      load_prog(p);
      @(negedge clk);
      start = 1'b1;
      mem_idle = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      stray = 0;
      repeat (8) begin
         @(negedge clk);
         if (valid) stray++;
      end
      chk("pre_rst_no_strobe", stray, 0);
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_addr", addr, 0);
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_instr", mem_instr, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_idle = 1'b1;
      clear_model_regs();
      stray = 0;
      repeat (10) begin
         @(negedge clk);
         if (valid || busy || done) stray++;
      end
      chk("post_rst_quiet", stray, 0);
      // r2 was set before the reset; a cleared r2 makes BNZ fall through
      p = '0;
      p[0] = 32'h3200_0300;
      p[1] = 32'hA000_0011;
      p[2] = 32'hF000_0000;
      p[3] = 32'hA000_0022;
      p[4] = 32'hF000_0000;
      load_prog(p);
      idle_all_high();
      model_run();
      run_dut(-1, 200);
      compare_run("after_rst");
      if (act_q.size() > 0) chk("after_rst_instr", act_q[0].instr, 32'hA000_0011);
      chk("after_rst_done", act_done, 10);

      // Random programs, forward-only branches, random idle and stray starts
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < IC; i++) begin
            w = $urandom;
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4: w[31:28] = 4'h6 + 4'($urandom_range(0, 4));
               5: w[31:28] = 4'h1;
               6: w[31:28] = 4'h2;
               7: begin
                  if (i < IC - 1) begin
                     w[31:28] = 4'h3;
                     w[23:8] = 16'($urandom_range(i + 1, IC - 1));
                  end else begin
                     w[31:28] = 4'h0;
                  end
               end
               8: begin
                  case ($urandom_range(0, 6))
                     0: w[31:28] = 4'h0;
                     1: w[31:28] = 4'h4;
                     2: w[31:28] = 4'h5;
                     3: w[31:28] = 4'hB;
                     4: w[31:28] = 4'hC;
                     5: w[31:28] = 4'hD;
                     default: w[31:28] = 4'hE;
                  endcase
               end
               default: w[31:28] = 4'hF;
            endcase
            prog[i] = w;
         end
         for (int i = 0; i < IDLE_LEN; i++) idle_pat[i] = ($urandom_range(0, 9) < 7);
         model_run();
         sa = (exp_done > 1) ? int'($urandom_range(0, exp_done - 1)) : -1;
         run_dut(sa, 800);
         compare_run($sformatf("rnd%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gpu_controller.md
Name: gpu_controller

Overview:
Instruction sequencer that fetches 32-bit instructions from the instruction BRAM and forwards memory-class opcodes to the memory module, one at a time, gated on the memory idle flag. Controller-class opcodes (register load, add, branch, halt) are executed locally against a private register file, which allows the matrix-multiply program to loop. The block drives the memory module's instr_in/instr_valid_in and replaces testbench-driven instruction streams.

Parameters:
INSTRUCTION_WIDTH, 32, instruction word width
INSTRUCTION_COUNT, 8, program length; PC range 0..INSTRUCTION_COUNT-1
PRIVATE_REG_WIDTH, 16, private register width
PRIVATE_REG_COUNT, 16, number of private registers
ROM_LATENCY, 2, instruction BRAM read latency in cycles

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low
start_in  input  1  one-cycle pulse: begin execution at PC 0
instr_addr_out  output  $clog2(INSTRUCTION_COUNT)  instruction BRAM read address
instr_data_in  input  INSTRUCTION_WIDTH  BRAM data, valid ROM_LATENCY cycles after address
memory_idle_in  input  1  memory module idle_out
memory_instr_out  output  INSTRUCTION_WIDTH  instruction to memory instr_in
memory_instr_valid_out  output  1  one-cycle issue strobe
busy_out  output  1  high from start until halt
done_out  output  1  one-cycle pulse on halt

Behaviour:
- Reset (rst_in==0 at a clock edge): state=IDLE, PC=0, all private regs=0, instr_addr_out=0, memory_instr_out=0, memory_instr_valid_out=0, busy_out=0, done_out=0. Reset asserted mid-program aborts immediately; no further issue.
- Field decode, MSB first: op=[31:28], rd=[27:24], imm=[23:8], low byte is passed through untouched.
- Opcode classes: memory-class 0110 SMA, 0111 LOADI, 1000 SENDL, 1001 LOADB, 1010 WRITEB are forwarded verbatim. Controller-class opcodes execute locally:
  - 0001 SETR: reg[rd]=imm.
  - 0010 ADDR: reg[rd]=reg[rd]+imm, mod 2^16 wrap.
  - 0011 BNZ: if reg[rd]!=0 then PC=imm[$clog2(INSTRUCTION_COUNT)-1:0], else PC+1.
  - 1111 HALT.
  - 0000 NOP and all other opcodes: no action, PC+1.
- FSM:
  - IDLE: wait for start_in; then PC=0, busy_out=1, go to FETCH.
  - FETCH: drive instr_addr_out=PC; count ROM_LATENCY cycles; latch instr_data_in; go to EXEC.
  - EXEC: memory-class goes to ISSUE; controller-class executes in this cycle and goes to FETCH with the new PC, or to HALT.
  - ISSUE: while memory_idle_in==0, hold with valid low. On the first cycle memory_idle_in==1, drive memory_instr_out=instr and memory_instr_valid_out=1 for exactly one cycle, PC+1, go to FETCH.
  - HALT: done_out=1 for one cycle, busy_out=0, go to IDLE.
- Fetch-to-issue latency with memory idle: address at cycle t, strobe at cycle t+ROM_LATENCY+1. Minimum period is ROM_LATENCY+2 cycles per memory instruction.
- PC boundary: incrementing past INSTRUCTION_COUNT-1 is an implicit HALT; PC never wraps to 0.
- start_in while busy is ignored. start_in and reset in the same cycle: reset wins.
- memory_instr_out holds its last issued value between strobes. Consumers qualify it with valid only.
- Private regs are invisible outside the block. Register index rd covers all 16 registers.

Decomposition:
- Shared package gpu_pkg holds:
  - opcode localparams (OP_NOP, OP_SETR, OP_ADDR, OP_BNZ, OP_SMA, OP_LOADI, OP_SENDL, OP_LOADB, OP_WRITEB, OP_HALT);
  - field bit positions;
  - ctrl_state_t enum {IDLE, FETCH, EXEC, ISSUE, HALT};
  - a function is_mem_op(op).
- One natural sub-module, private_reg_file: 16x16 registers, one write port, one combinational read port, synchronous active-low clear.

Test Plan:
- Straight-line program SMA(addr 1), LOADI x6, SENDL, HALT with memory_idle_in=1: 8 strobes, in order and verbatim, each ROM_LATENCY+2=4 cycles apart; then done_out pulse and busy_out=0.
- Stall: hold memory_idle_in=0 for 5 cycles after WRITEB is fetched: no strobe while idle is low, then exactly one strobe in the cycle idle rises; the instruction is never duplicated.
- Loop: SETR r1=3; WRITEB; ADDR r1+=0xFFFF; BNZ r1 ->1; HALT. Required: exactly 3 WRITEB strobes, r1 ends at 0, then done.
- PC overrun: program of NOPs with no HALT and INSTRUCTION_COUNT=8: done_out pulses after PC 7, instr_addr_out never wraps to 0, no strobes.
- Reset mid-ISSUE (memory_idle_in=0, then rst_in=0 for one cycle): all outputs go to reset values and no strobe ever occurs. A following start_in restarts from PC 0 with registers cleared.
- start_in while busy plus unknown opcode 0100: the start is ignored and the program is not restarted; 0100 is treated as NOP with no strobe.
